// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: EXE_CMD encodings and NZCV bit positions.
package alu_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and NZCV for one EXE_CMD, given the current status.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       cmd_i,
  input  logic [WIDTH-1:0] val1_i,
  input  logic [WIDTH-1:0] val2_i,
  input  logic [3:0]       status_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       nzcv_o,
  output logic             illegal_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] opb;
  logic             cin;
  logic             arith;
  logic             sub;

  // Decode the command, run the shared adder, and derive flags.
  // Subtract forms reuse the adder as a + ~b + cin, so C is "no borrow".
  always_comb begin
    opb       = val2_i;
    cin       = 1'b0;
    arith     = 1'b0;
    sub       = 1'b0;
    illegal_o = 1'b0;
    result_o  = '0;
    case (cmd_i)
      CMD_MOV: result_o = val2_i;
      CMD_MVN: result_o = ~val2_i;
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin
        arith = 1'b1;
        cin   = status_i[FLAG_C];
      end
      CMD_SUB: begin
        arith = 1'b1;
        sub   = 1'b1;
        opb   = ~val2_i;
        cin   = 1'b1;
      end
      CMD_SBC: begin
        arith = 1'b1;
        sub   = 1'b1;
        opb   = ~val2_i;
        cin   = status_i[FLAG_C];
      end
      CMD_AND: result_o = val1_i & val2_i;
      CMD_ORR: result_o = val1_i | val2_i;
      CMD_EOR: result_o = val1_i ^ val2_i;
      default: illegal_o = 1'b1;
    endcase

    sum = {1'b0, val1_i} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
    if (arith) begin
      result_o = sum[WIDTH-1:0];
    end

    // Undefined commands report the status unchanged; logical ops keep C/V.
    nzcv_o = status_i;
    if (!illegal_o) begin
      nzcv_o[FLAG_N] = result_o[WIDTH-1];
      nzcv_o[FLAG_Z] = (result_o == '0);
    end
    if (arith) begin
      nzcv_o[FLAG_C] = sum[WIDTH];
      if (sub) begin
        nzcv_o[FLAG_V] = (val1_i[WIDTH-1] != val2_i[WIDTH-1]) &&
                         (result_o[WIDTH-1] != val1_i[WIDTH-1]);
      end else begin
        nzcv_o[FLAG_V] = (val1_i[WIDTH-1] == val2_i[WIDTH-1]) &&
                         (result_o[WIDTH-1] != val1_i[WIDTH-1]);
      end
    end
  end

endmodule : alu_core

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready handshake and the architectural NZCV register.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_cmd,
  input  logic [WIDTH-1:0] in_val1,
  input  logic [WIDTH-1:0] in_val2,
  input  logic             in_s,
  input  logic             in_wb,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_nzcv,
  output logic             out_wb,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       status,
  input  logic             status_ld,
  input  logic [3:0]       status_din
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       nzcv_q, nzcv_d;
  logic             wb_q, wb_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [3:0]       status_q, status_d;

  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_nzcv;
  logic             core_illegal;
  logic             accept;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .cmd_i    (in_cmd),
    .val1_i   (in_val1),
    .val2_i   (in_val2),
    .status_i (status_q),
    .result_o (core_result),
    .nzcv_o   (core_nzcv),
    .illegal_o(core_illegal)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next-state for the output register and the status register.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    nzcv_d      = nzcv_q;
    wb_d        = wb_q;
    tag_d       = tag_q;
    status_d    = status_q;

    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = core_result;
      nzcv_d      = core_nzcv;
      wb_d        = in_wb && !core_illegal;
      tag_d       = in_tag;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // A flag-setting op in flight takes priority over an MSR load.
    if (accept && in_s) begin
      status_d = core_nzcv;
    end else if (status_ld) begin
      status_d = status_din;
    end
  end

  // State update with synchronous reset; reset also drops any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      nzcv_q      <= '0;
      wb_q        <= 1'b0;
      tag_q       <= '0;
      status_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      nzcv_q      <= nzcv_d;
      wb_q        <= wb_d;
      tag_q       <= tag_d;
      status_q    <= status_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_nzcv   = nzcv_q;
  assign out_wb     = wb_q;
  assign out_tag    = tag_q;
  assign status     = status_q;

endmodule : alu_pipe

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus randomized traffic against a reference model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_cmd;
  logic [31:0] in_val1, in_val2;
  logic        in_s, in_wb;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_nzcv;
  logic        out_wb;
  logic [3:0]  out_tag;
  logic [3:0]  status;
  logic        status_ld;
  logic [3:0]  status_din;

  logic        b8_in_valid, b8_in_ready;
  logic [3:0]  b8_in_cmd;
  logic [7:0]  b8_in_val1, b8_in_val2;
  logic        b8_in_s, b8_in_wb;
  logic [3:0]  b8_in_tag;
  logic        b8_out_valid;
  logic [7:0]  b8_out_result;
  logic [3:0]  b8_out_nzcv;
  logic        b8_out_wb;
  logic [3:0]  b8_out_tag;
  logic [3:0]  b8_status;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state.
  logic        m_valid;
  logic [31:0] m_result;
  logic [3:0]  m_nzcv;
  logic        m_wb;
  logic [3:0]  m_tag;
  logic [3:0]  m_status;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .TAG_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_val1(in_val1), .in_val2(in_val2), .in_s(in_s), .in_wb(in_wb), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_nzcv(out_nzcv), .out_wb(out_wb), .out_tag(out_tag),
    .status(status), .status_ld(status_ld), .status_din(status_din)
  );

  alu_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(b8_in_valid), .in_ready(b8_in_ready), .in_cmd(b8_in_cmd),
    .in_val1(b8_in_val1), .in_val2(b8_in_val2), .in_s(b8_in_s), .in_wb(b8_in_wb),
    .in_tag(b8_in_tag),
    .out_valid(b8_out_valid), .out_ready(1'b1), .out_result(b8_out_result),
    .out_nzcv(b8_out_nzcv), .out_wb(b8_out_wb), .out_tag(b8_out_tag),
    .status(b8_status), .status_ld(1'b0), .status_din(4'b0000)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Arithmetic reference: works on mathematical integers, then wraps to w bits.
  function automatic void ref_alu(input int w, input logic [3:0] cmd,
                                  input longint a, input longint b, input logic [3:0] st,
                                  output longint r, output logic [3:0] f, output bit ill);
    longint m, sa, sb, s;
    bit c, v, arith;
    m = longint'(1) << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    c = st[1];
    v = st[0];
    s = 0;
    ill = 0;
    arith = 1;
    case (cmd)
      4'd2: begin r = a + b;          c = (r >= m);             s = sa + sb; end
      4'd3: begin r = a + b + st[1];  c = (r >= m);             s = sa + sb + st[1]; end
      4'd4: begin r = a - b;          c = (a >= b);             s = sa - sb; end
      4'd5: begin r = a - b - (1 - st[1]); c = (a >= b + 1 - st[1]); s = sa - sb - (1 - st[1]); end
      default: begin
        arith = 0;
        case (cmd)
          4'd1: r = b;
          4'd9: r = ~b;
          4'd6: r = a & b;
          4'd7: r = a | b;
          4'd8: r = a ^ b;
          default: begin r = 0; ill = 1; end
        endcase
      end
    endcase
    r = r & (m - 1);
    if (arith) v = (s >= m / 2) || (s < -(m / 2));
    if (ill) f = st;
    else     f = {r >= m / 2, r == 0, c, v};
  endfunction

  // One clock of the 32-bit DUT: inputs are already driven (after a negedge).
  task automatic step();
    longint     r;
    logic [3:0] f;
    bit         ill, acc;
    #1;
    if (!rst) check("in_ready", in_ready, !m_valid || out_ready);
    acc = !rst && in_valid && (!m_valid || out_ready);
    ref_alu(32, in_cmd, longint'(in_val1), longint'(in_val2), m_status, r, f, ill);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_result = '0; m_nzcv = '0; m_wb = 0; m_tag = '0; m_status = '0;
    end else begin
      if (acc) begin
        m_valid = 1; m_result = r[31:0]; m_nzcv = f; m_wb = in_wb && !ill; m_tag = in_tag;
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (acc && in_s) m_status = f;
      else if (status_ld) m_status = status_din;
    end
    #1;
    check("out_valid", out_valid, m_valid);
    check("status", status, m_status);
    if (m_valid || rst) begin
      check("out_result", out_result, m_result);
      check("out_nzcv", out_nzcv, m_nzcv);
      check("out_wb", out_wb, m_wb);
      check("out_tag", out_tag, m_tag);
    end
  endtask

  task automatic op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                    input logic s, input logic wb, input logic rdy);
    @(negedge clk);
    in_valid = 1; in_cmd = cmd; in_val1 = a; in_val2 = b; in_s = s; in_wb = wb;
    in_tag = 4'($urandom_range(0, 15)); out_ready = rdy; status_ld = 0;
    step();
  endtask

  task automatic load_status(input logic [3:0] v);
    @(negedge clk);
    in_valid = 0; out_ready = 1; status_ld = 1; status_din = v;
    step();
  endtask

  initial begin
    rst = 1; in_valid = 1; in_cmd = 4'd2; in_val1 = 1; in_val2 = 1; in_s = 1; in_wb = 1;
    in_tag = 4'd3; out_ready = 1; status_ld = 0; status_din = '0;
    b8_in_valid = 0; b8_in_cmd = '0; b8_in_val1 = '0; b8_in_val2 = '0;
    b8_in_s = 0; b8_in_wb = 0; b8_in_tag = '0;
    m_valid = 0; m_result = '0; m_nzcv = '0; m_wb = 0; m_tag = '0; m_status = '0;

    // Reset for two cycles with in_valid held high.
    repeat (2) begin @(negedge clk); step(); end
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_status", status, 4'b0000);
    @(negedge clk); rst = 0; in_valid = 0;
    #1 check("post_rst_in_ready", in_ready, 1'b1);
    step();

    op(4'd2, 32'h7FFF_FFFF, 32'h1, 1, 1, 1);
    check("adds_res", out_result, 32'h8000_0000);
    check("adds_nzcv", out_nzcv, 4'b1001);
    op(4'd3, 32'h0, 32'h0, 0, 1, 1);
    check("adc_res", out_result, 32'h0);

    op(4'd4, 32'd5, 32'd5, 1, 1, 1);
    check("subs_res", out_result, 32'h0);
    check("subs_nzcv", out_nzcv, 4'b0110);
    op(4'd5, 32'd5, 32'd3, 0, 1, 1);
    check("sbc_res", out_result, 32'd2);
    op(4'd4, 32'd0, 32'd1, 1, 1, 1);
    check("subs_neg_res", out_result, 32'hFFFF_FFFF);
    check("subs_neg_nzcv", out_nzcv, 4'b1000);

    // Stall: hold the EOR result for three cycles.
    op(4'd8, 32'h0000_F0F0, 32'h0000_0FF0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      op(4'd2, 32'd1, 32'd1, 0, 1, 0);
      check("stall_res", out_result, 32'h0000_FF00);
      check("stall_in_ready", in_ready, 1'b0);
    end
    op(4'd2, 32'd1, 32'd1, 0, 1, 1);
    check("drain_accept_res", out_result, 32'd2);
    check("drain_accept_valid", out_valid, 1'b1);

    // MSR load versus flag-setting MOV.
    load_status(4'b0000);
    @(negedge clk);
    in_valid = 1; in_cmd = 4'd1; in_val1 = 0; in_val2 = 0; in_s = 1; in_wb = 1;
    out_ready = 1; status_ld = 1; status_din = 4'b1111;
    step();
    check("movs_vs_ld", status, 4'b0100);
    load_status(4'b0011);
    op(4'd1, 32'h0, 32'h0, 1, 1, 1);
    check("movs_keep_cv", status, 4'b0111);

    // Undefined command.
    op(4'hF, 32'h1234, 32'h5678, 1, 1, 1);
    check("undef_res", out_result, 32'h0);
    check("undef_wb", out_wb, 1'b0);
    check("undef_status", status, 4'b0111);

    // Reset while stalled discards the held result.
    op(4'd7, 32'h1, 32'h2, 0, 1, 0);
    op(4'd7, 32'h1, 32'h2, 0, 1, 0);
    @(negedge clk); rst = 1; step();
    check("rst_stall_valid", out_valid, 1'b0);
    @(negedge clk); rst = 0; in_valid = 0; out_ready = 1; step();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 99) < 2);
      in_valid   = ($urandom_range(0, 99) < 75);
      out_ready  = ($urandom_range(0, 99) < 70);
      in_cmd     = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: begin in_val1 = 32'h7FFF_FFFF; in_val2 = $urandom; end
        1: begin in_val1 = 32'h8000_0000; in_val2 = 32'hFFFF_FFFF; end
        2: begin in_val1 = $urandom;      in_val2 = in_val1; end
        default: begin in_val1 = $urandom; in_val2 = $urandom; end
      endcase
      in_s       = $urandom_range(0, 1);
      in_wb      = $urandom_range(0, 1);
      in_tag     = 4'($urandom_range(0, 15));
      status_ld  = ($urandom_range(0, 99) < 10);
      status_din = 4'($urandom_range(0, 15));
      step();
    end
    @(negedge clk); rst = 0; in_valid = 0; status_ld = 0; out_ready = 1; step();

    // 8-bit instance: ADDS 0x80 + 0x80.
    @(negedge clk);
    b8_in_valid = 1; b8_in_cmd = 4'd2; b8_in_val1 = 8'h80; b8_in_val2 = 8'h80;
    b8_in_s = 1; b8_in_wb = 1; b8_in_tag = 4'd9;
    @(posedge clk); #1;
    check("w8_res", b8_out_result, 8'h00);
    check("w8_nzcv", b8_out_nzcv, 4'b0111);
    check("w8_status", b8_status, 4'b0111);
    check("w8_tag", b8_out_tag, 4'd9);
    @(negedge clk); b8_in_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_alu_pipe

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the execute-stage ALU: performs the nine ARM data-processing commands on WIDTH-bit operands, computes correct N/Z/C/V flags, and owns the architectural NZCV status register. Sits between the ID/EX pipeline register and the EX/MEM register. A valid/ready handshake on both sides lets the memory stage stall it without losing results. A tag and write-back enable travel with each operation.

## Interface
- WIDTH, 32, operand/result width (≥ 2)
- TAG_W, 4, width of pass-through tag (destination register index)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- in_cmd  in  4  EXE_CMD: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR
- in_val1, in_val2  in  WIDTH  operands (val2 already shifted)
- in_s  in  1  update status register with this op's flags
- in_wb  in  1  write-back enable, passed through
- in_tag  in  TAG_W  passed through
- out_valid  out  1  result held
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_result  out  WIDTH  registered result
- out_nzcv  out  4  flags of this op {N,Z,C,V}
- out_wb, out_tag  out  1/TAG_W  registered pass-through
- status  out  4  architectural NZCV register
- status_ld  in  1  load status from status_din (MSR path)
- status_din  in  4  value for status_ld

## Operation
- Compute on a WIDTH+1-bit sum; C = bit WIDTH of the sum.
- ADD: r = a+b. ADC: a+b+C_status. SUB: a+~b+1. SBC: a+~b+C_status. C for SUB/SBC is "no borrow".
- V (add forms): a[MSB]==b[MSB] && r[MSB]!=a[MSB]. V (sub forms): a[MSB]!=b[MSB] && r[MSB]!=a[MSB].
- N = r[MSB]; Z = (r==0).
- Logical/move ops (MOV, MVN, AND, ORR, EOR): C and V take the current status C and V values unchanged.
- Undefined cmd: r = 0, flags = current status, in_wb forced to 0 in the output.
- On acceptance with in_s=1, status ← new NZCV at the same edge. With in_s=0, status is unchanged. out_nzcv always carries the computed flags.
- status_ld together with an accepted in_s=1 op: the op's flags win. status_ld otherwise loads status_din.

## Timing
- Latency 1: accepted at edge k, out_valid and data at edge k+1.
- in_ready = !out_valid || out_ready. Full throughput of one op per cycle under no stall.
- Status written at acceptance edge k. An ADC/SBC accepted at edge k+1 uses the updated C, so back-to-back flag dependence needs no bubble.
- Stall (out_valid && !out_ready): out_* held stable, in_ready=0, status unchanged by the pipe. status_ld is still honoured.
- Simultaneous drain and accept: output replaced with the new op, out_valid stays 1.
- Reset values: out_valid=0, out_result=0, out_nzcv=0, out_wb=0, out_tag=0, status=0. in_ready=1 the cycle after reset.
- Reset mid-stall discards the held result. in_valid is ignored while rst=1.

## Structure
- Shared package alu_pkg: the EXE_CMD localparams (CMD_MOV … CMD_EOR), NZCV bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One combinational sub-module alu_core (WIDTH): inputs cmd, val1, val2, status C/V; outputs result, nzcv, illegal.
- alu_pipe holds the output register, handshake, and status register.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 → out_valid=0, status=0000; first cycle after reset in_ready=1.
- WIDTH=32, ADDS 0x7FFFFFFF+1 → result 0x80000000, nzcv 1001. Then ADC 0+0 next cycle → result 0, C_status=0 used.
- SUBS 5−5 → result 0, nzcv 0110. Then SBC 5−3 back-to-back → result 2 (C=1 consumed). SUBS 0−1 → 0xFFFFFFFF, nzcv 1000.
- Stall: hold out_ready=0 for 3 cycles after EOR 0xF0F0^0x0FF0 → out_result 0xFF00 stable, in_ready=0, next op not accepted until out_ready=1.
- status_ld=1, din=1111 on the same edge as accepted MOVS 0 → status=0100. MOVS keeps C=1 and V=1 from the prior status 0011.
- Undefined cmd 1111 with in_wb=1, in_s=1 → result 0, out_wb=0, status unchanged. Repeat with WIDTH=8: ADDS 0x80+0x80 → 0x00, nzcv 0111.
